// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - op encodings and FSM states for seq_arith_unit
package arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/seq_arith_unit_if.sv
// rtl/seq_arith_unit_if.sv - start/done operand and result bundle for seq_arith_unit
interface seq_arith_unit_if #(parameter int W = 8);

  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] z;
  logic           ovf;
  logic           div_by_zero;

  modport master (output start, op, a, b, input busy, done, z, ovf, div_by_zero);
  modport slave  (input start, op, a, b, output busy, done, z, ovf, div_by_zero);

endinterface

// File: rtl/addsub_w.sv
// rtl/addsub_w.sv - W+1 bit adder/subtractor shared by add/sub, Booth and divide steps
module addsub_w #(
  parameter int W = 8
) (
  input  logic [W:0] x,
  input  logic [W:0] y,
  input  logic       sub,
  output logic [W:0] sum,
  output logic       carry
);

  logic [W+1:0] full;

  // carry is the unsigned no-borrow flag when subtracting
  assign full         = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{(W+1){1'b0}}, sub};
  assign {carry, sum} = full;

endmodule

// File: rtl/seq_arith_unit.sv
// rtl/seq_arith_unit.sv - self-sequencing add/sub/Booth mul/restoring div unit
// Define SIGNED_DIV_EN for signed divide with a sign-fix state after RUN.
module seq_arith_unit
  import arith_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  seq_arith_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(W) + 1;

  state_e           state, state_nx;
  logic             busy_c, done_c, accept;
  logic [1:0]       op_q;
  logic [W-1:0]     a_q, b_q;
  logic [W-1:0]     acc, qr, m;
  logic             qm1;
  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0]   z_q;
  logic             ovf_q, dbz_q;

  logic [W:0]       add_x, add_y, add_sum;
  logic             add_sub, add_carry;
  logic [W-1:0]     acc_nx, qr_nx;
  logic             qm1_nx;
  logic [W-1:0]     div_q0, div_m0;

  assign accept = bus.start && (state == IDLE || state == DONE);

  addsub_w #(.W(W)) u_addsub (
    .x     (add_x),
    .y     (add_y),
    .sub   (add_sub),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Outside RUN the adder serves the single-cycle add/sub on live inputs
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_sub = 1'b0;
    if (state == RUN) begin
      if (op_q == OP_MUL) begin
        add_x   = {acc[W-1], acc};
        add_y   = (qr[0] ^ qm1) ? {m[W-1], m} : '0;
        add_sub = qr[0] & ~qm1;
      end else begin
        add_x   = {acc, qr[W-1]};
        add_y   = {1'b0, m};
        add_sub = 1'b1;
      end
    end else begin
      add_x   = {bus.a[W-1], bus.a};
      add_y   = {bus.b[W-1], bus.b};
      add_sub = bus.op[0];
    end
  end

  always_comb begin
    acc_nx = acc;
    qr_nx  = qr;
    qm1_nx = qm1;
    if (op_q == OP_MUL) begin
      acc_nx = add_sum[W:1];
      qr_nx  = {add_sum[0], qr[W-1:1]};
      qm1_nx = qr[0];
    end else if (add_carry) begin
      acc_nx = add_sum[W-1:0];
      qr_nx  = {qr[W-2:0], 1'b1};
    end else begin
      acc_nx = {acc[W-2:0], qr[W-1]};
      qr_nx  = {qr[W-2:0], 1'b0};
    end
  end

`ifdef SIGNED_DIV_EN
  logic [W-1:0] fix_q, fix_r;
  logic         div_ovf;

  assign div_q0  = a_q[W-1] ? (~a_q + W'(1)) : a_q;
  assign div_m0  = b_q[W-1] ? (~b_q + W'(1)) : b_q;
  // quotient sign follows the operand signs, remainder follows the dividend
  assign fix_q   = (a_q[W-1] ^ b_q[W-1]) ? (~qr + W'(1)) : qr;
  assign fix_r   = a_q[W-1] ? (~acc + W'(1)) : acc;
  assign div_ovf = (a_q == {1'b1, {(W-1){1'b0}}}) && (&b_q);
`else
  assign div_q0 = a_q;
  assign div_m0 = b_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    case (state)
      IDLE, DONE: begin
        done_c = (state == DONE);
        if (accept) state_nx = bus.op[1] ? LOAD : DONE;
        else        state_nx = IDLE;
      end
      LOAD: begin
        busy_c   = 1'b1;
        state_nx = (op_q == OP_DIV && b_q == '0) ? DONE : RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        if (cnt == CNT_W'(W - 1)) begin
`ifdef SIGNED_DIV_EN
          state_nx = (op_q == OP_DIV) ? FIX : DONE;
`else
          state_nx = DONE;
`endif
        end
      end
      FIX: begin
        busy_c   = 1'b1;
        state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q  <= OP_ADD;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      qr    <= '0;
      m     <= '0;
      qm1   <= 1'b0;
      cnt   <= '0;
      z_q   <= '0;
      ovf_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            op_q  <= bus.op;
            ovf_q <= 1'b0;
            dbz_q <= 1'b0;
            if (!bus.op[1]) begin
              z_q   <= {{(W-1){add_sum[W]}}, add_sum};
              ovf_q <= add_sum[W] ^ add_sum[W-1];
            end
          end
        end
        LOAD: begin
          acc <= '0;
          qm1 <= 1'b0;
          cnt <= '0;
          if (op_q == OP_MUL) begin
            qr <= b_q;
            m  <= a_q;
          end else begin
            qr <= div_q0;
            m  <= div_m0;
            if (b_q == '0) begin
              z_q   <= {a_q, {W{1'b1}}};
              dbz_q <= 1'b1;
            end
          end
        end
        RUN: begin
          acc <= acc_nx;
          qr  <= qr_nx;
          qm1 <= qm1_nx;
          cnt <= cnt + CNT_W'(1);
          if (state_nx == DONE) z_q <= {acc_nx, qr_nx};
        end
`ifdef SIGNED_DIV_EN
        FIX: begin
          acc   <= fix_r;
          qr    <= fix_q;
          z_q   <= {fix_r, fix_q};
          ovf_q <= div_ovf;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.z           = z_q;
  assign bus.ovf         = ovf_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// tb/tb_seq_arith_unit.sv - scoreboard bench for seq_arith_unit at W=8
module tb_seq_arith_unit;
  import arith_pkg::*;

  localparam int W = 8;
`ifdef SIGNED_DIV_EN
  localparam int DIV_LAT = W + 3;
`else
  localparam int DIV_LAT = W + 2;
`endif

  typedef struct {
    logic [2*W-1:0] z;
    logic           ovf;
    logic           dbz;
    int             due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seq_arith_unit_if #(.W(W)) bus ();

  seq_arith_unit #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("z", 32'(bus.z), 32'(e.z));
        chk("ovf", 32'(bus.ovf), 32'(e.ovf));
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
        chk("done_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic [2*W-1:0] ez, input logic eo, input logic ed, input int lat);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = xa;
    bus.b     = xb;
    e.z = ez; e.ovf = eo; e.dbz = ed; e.due = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int   n;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.op = OP_ADD;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_z", 32'(bus.z), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    chk("rst_dbz", 32'(bus.div_by_zero), 0);
    rst = 1'b1;

    issue(OP_ADD, 8'h7F, 8'h01, 16'h0080, 1'b1, 1'b0, 1);                drain();
    issue(OP_SUB, 8'h80, 8'h01, 16'hFF7F, 1'b1, 1'b0, 1);                drain();
    issue(OP_ADD, 8'hFE, 8'h03, 16'h0001, 1'b0, 1'b0, 1);                drain();

    issue(OP_MUL, 8'hFD, 8'h05, 16'hFFF1, 1'b0, 1'b0, W + 2);
    for (int i = 1; i <= W + 1; i++) begin
      chk($sformatf("mul_busy_c%0d", i), 32'(bus.busy), 1);
      @(negedge clk);
    end
    chk("mul_busy_done", 32'(bus.busy), 0);
    drain();
    issue(OP_MUL, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b0, W + 2);            drain();

`ifdef SIGNED_DIV_EN
    issue(OP_DIV, 8'hC8, 8'h07, 16'h00F8, 1'b0, 1'b0, DIV_LAT);          drain();
    issue(OP_DIV, 8'hF9, 8'h02, 16'hFFFD, 1'b0, 1'b0, DIV_LAT);          drain();
    issue(OP_DIV, 8'h80, 8'hFF, 16'h0080, 1'b1, 1'b0, DIV_LAT);          drain();
`else
    issue(OP_DIV, 8'hC8, 8'h07, 16'h041C, 1'b0, 1'b0, DIV_LAT);          drain();
    issue(OP_DIV, 8'hF9, 8'h02, 16'h017C, 1'b0, 1'b0, DIV_LAT);          drain();
    issue(OP_DIV, 8'h80, 8'hFF, 16'h8000, 1'b0, 1'b0, DIV_LAT);          drain();
`endif
    issue(OP_DIV, 8'h55, 8'h00, 16'h55FF, 1'b0, 1'b1, 2);                drain();
    issue(OP_DIV, 8'h0A, 8'h0A, 16'h0001, 1'b0, 1'b0, DIV_LAT);          drain();

    // start held high while busy must not retrigger
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MUL; bus.a = 8'h02; bus.b = 8'h03;
    e.z = 16'h0006; e.ovf = 1'b0; e.dbz = 1'b0; e.due = cyc + W + 2;
    sb.push_back(e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.a = W'($urandom); bus.b = W'($urandom);
    end
    bus.start = 1'b0;
    drain();

    // back-to-back start on the done cycle
    issue(OP_MUL, 8'h07, 8'h06, 16'h002A, 1'b0, 1'b0, W + 2);
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", 32'(bus.done), 1);
    bus.start = 1'b1; bus.op = OP_ADD; bus.a = 8'h01; bus.b = 8'h02;
    e.z = 16'h0003; e.ovf = 1'b0; e.dbz = 1'b0; e.due = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // reset mid-multiply: abort without a done pulse
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MUL; bus.a = 8'h11; bus.b = 8'h22;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_z", 32'(bus.z), 0);
    chk("abort_done", 32'(bus.done), 0);
    repeat (15) @(negedge clk);
    chk("abort_idle_busy", 32'(bus.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
Parametrised, self-sequencing add/sub/multiply/divide unit. It replaces the externally sequenced 8-bit datapath with an internal FSM, shift counter and start/done handshake. It sits between the operand registers and the result bus, and the control unit only issues `start` and `op`. Multiply uses radix-2 Booth (signed); divide uses restoring shift-subtract.

Parameters:
W, 8, operand width in bits (4..32)
CNT_W, $clog2(W)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
start  in  1  request; sampled only when not busy
op  in  2  00 add, 01 sub, 10 mul, 11 div
a  in  W  operand A / multiplicand / dividend
b  in  W  operand B / multiplier / divisor
busy  out  1  operation in progress; start ignored
done  out  1  one-cycle pulse, z/flags valid
z  out  2W  result register
ovf  out  1  add/sub signed overflow of W-bit result; signed-div overflow
div_by_zero  out  1  set with done when op=11 and b==0

Behaviour:
- Reset: one clock is used, and the reset is synchronous and active-low (`rst` low on a rising clk edge).
  - Reset state: IDLE; busy=0, done=0, z=0, ovf=0, div_by_zero=0, counter=0, Booth extra bit q[-1]=0.
  - Reset mid-operation aborts it; no done pulse is produced.
- FSM states: IDLE, LOAD, RUN, FIX (SIGNED_DIV_EN only), DONE.
- Start acceptance: start is accepted in IDLE or DONE. a, b and op are captured on the accepting edge; later changes are ignored.
- Add/sub path (op=00/01):
  - Accepting edge goes straight to DONE; done is high the cycle after start.
  - Operands are signed. z = (W+1)-bit result sign-extended to 2W.
  - ovf = signed overflow of the W-bit truncated result.
- Mul path (op=10):
  - LOAD: A=0, Q=b, M=a, q[-1]=0, counter=0.
  - RUN, W cycles. Per cycle:
    - Q0,q[-1] = 10 → A -= M
    - Q0,q[-1] = 01 → A += M
    - then arithmetic right shift of {A,Q,q[-1]}
    - counter++
  - Exit RUN when counter==W-1 on the shifting edge. DONE then loads z={A,Q}, a signed 2W product.
  - Latency: done at cycle W+2 after the start cycle.
- Div path (op=11), unsigned:
  - LOAD: A=0, Q=a, M=b.
  - If b==0 in LOAD: go to DONE with z={a, all-ones}, div_by_zero=1, and skip RUN.
  - RUN, W cycles. Per cycle:
    - shift {A,Q} left
    - trial A-M (W+1 bits)
    - if non-negative: A=A-M, Q0=1; else keep A, Q0=0
  - DONE: z={remainder A, quotient Q}. Latency W+2.
- Handshake rules:
  - busy=1 in LOAD, RUN and FIX.
  - done=1 only in DONE, for exactly one cycle. DONE returns to IDLE unless start is high, which is accepted back-to-back.
  - z, ovf and div_by_zero hold their values until the next accepted start, which clears the flags.
- Width rules:
  - Adder is W+1 bits wide, so there is no loss on A±M.
  - Counter compare is against W-1; no wrap-around is permitted.

Optional Feature:
SIGNED_DIV_EN
- Defined:
  - op=11 treats a and b as signed. LOAD takes magnitudes.
  - The FIX state (1 cycle) after RUN negates the quotient if the signs differ, and negates the remainder if a<0 (truncation toward zero). Latency becomes W+3.
  - Most-negative ÷ −1 gives z={0, 100…0} with ovf=1.
  - Divide by zero is unchanged.
- Undefined: unsigned divide only, no FIX state, and ovf is always 0 for div.

Decomposition:
- Package arith_pkg:
  - op encodings OP_ADD/OP_SUB/OP_MUL/OP_DIV
  - state enum (IDLE, LOAD, RUN, FIX, DONE)
- Natural sub-module: addsub_w. It is a W+1-bit adder/subtractor (x, y, sub → sum, carry) shared by the add/sub, Booth and restoring-divide steps.
- FSM, counter and A/Q/M registers live in the top module.

Test Plan:
- W=8, add a=0x7F b=0x01 → done 1 cycle after start, z=0x0080, ovf=1.
- W=8, mul a=−3 (0xFD) b=5 → done at cycle 10, z=0xFFF1, busy high for cycles 1..9.
- W=8, div a=200 b=7 → z=0x041C (rem 4, quot 28), div_by_zero=0, done at cycle 10.
- W=8, div b=0 a=0x55 → z=0x55FF, div_by_zero=1, no RUN cycles, done at cycle 2.
- Mid-mul reset: rst=0 at cycle 5 → next edge IDLE, z=0, no done pulse. A start held high during busy is ignored; a start on the done cycle is accepted back-to-back.
- SIGNED_DIV_EN, W=8: a=−7 b=2 → quot −3 (0xFD), rem −1 (0xFF), z=0xFFFD. a=0x80 b=0xFF → z=0x0080, ovf=1.
